data_mem_access_unit: RTL and testbench
=======================================

# data_mem_access_unit

Initiator side of the data-memory interface: sits between the CPU execute stage and the data memory. Converts load, store, push and pop requests into single-cycle memory write or read strobes. Owns the stack pointer for the stack region and returns one response per accepted request, with an error flag for illegal accesses.

## Interface
Parameters:
- `MEM_WORDS`, 16: words in the data region; byte addresses 0 .. 2*MEM_WORDS-1.
- `STACK_WORDS`, 32: words in the stack region, placed directly above the data region.
- Derived constants:
  - STACK_BASE = 2*MEM_WORDS (0x0020).
  - STACK_TOP = 2*(MEM_WORDS+STACK_WORDS) (0x0060).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; a request is accepted on an edge where req_valid && req_ready.
- `req_op`  in  2  operation: 00 load, 01 store, 10 push, 11 pop.
- `req_addr`  in  16  byte address for load/store; ignored for push/pop.
- `req_wdata`  in  16  store/push data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  16  load/pop data; 0 for store, push and error responses.
- `rsp_err`  out  1  qualifies rsp_valid; request rejected.
- `sp`  out  16  current stack pointer (byte address).
- `mem_we`  out  1  memory write strobe.
- `mem_re`  out  1  memory read strobe.
- `mem_addr`  out  16  memory byte address.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data; valid the cycle after mem_re is asserted.

## Operation
- States: IDLE, WRITE, READ, WAIT, RESP. req_ready = (state==IDLE) && rst_n.
- On accept in IDLE, the request is checked for errors, then routed:
  - load/store error: req_addr[0]=1 or req_addr >= STACK_TOP.
  - push error: sp == STACK_BASE (stack full).
  - pop error: sp == STACK_TOP (stack empty).
  - error: go to RESP with rsp_err=1. No memory strobe; sp unchanged.
  - store: latch mem_addr=req_addr and mem_wdata=req_wdata, go to WRITE.
  - push: sp <= sp-2, latch mem_addr=sp-2 and mem_wdata=req_wdata, go to WRITE.
  - load: latch mem_addr=req_addr, go to READ.
  - pop: latch mem_addr=sp, sp <= sp+2, go to READ.
- WRITE: mem_we=1 for exactly this cycle, then RESP.
- READ: mem_re=1 for exactly this cycle, then WAIT.
- WAIT: capture mem_rdata into rsp_rdata at the end of this cycle, then RESP.
- RESP: rsp_valid=1 for one cycle; no backpressure. Then IDLE.
- Stack behaviour:
  - Full-descending; the empty value is sp=STACK_TOP.
  - Load and store may address stack words directly.
  - sp arithmetic is 16-bit; the error checks prevent any wrap.
- Address and data outputs:
  - mem_addr and mem_wdata hold their last values outside WRITE/READ.
  - mem_we and mem_re are never both high.
- req_valid while not ready is ignored. The requester holds the request until it is accepted.

## Timing
- Let T be the accept edge:
  - store/push: mem_we high in cycle T+1, rsp_valid in T+2.
  - load/pop: mem_re high in T+1, data captured at the end of T+2, rsp_valid in T+3.
  - error: rsp_valid with rsp_err=1 in T+1.
- req_ready returns high in the cycle after RESP. Maximum rate is one store per 3 cycles and one load per 4 cycles.
- sp shows its new value from T+1.
- Reset (rst_n low at an edge, in any state, including mid-operation):
  - state=IDLE, sp=STACK_TOP.
  - mem_we, mem_re, rsp_valid, rsp_err = 0.
  - rsp_rdata, mem_addr, mem_wdata = 0.
  - An in-flight request is dropped with no response.

## Test plan
- Reset: hold rst_n low 2 cycles.
  - During reset: req_ready=0, mem_we=mem_re=rsp_valid=0, sp=0x0060.
  - First cycle after release: req_ready=1.
- Store then load: store 0x00A5 to 0x0004, then load 0x0004.
  - Store: mem_we=1 with mem_addr=0x0004 and mem_wdata=0x00A5 in T+1 only; rsp_valid at T+2 with rsp_err=0.
  - Load: mem_re at T+1; rsp_valid at T+3 with rsp_rdata=0x00A5.
- Illegal load/store: load at 0x0003, then store at 0x0060.
  - Each gives rsp_valid with rsp_err=1 at T+1.
  - mem_we and mem_re never assert.
- Stack fill and drain: push 1..32.
  - sp steps 0x005E down to 0x0020.
  - 33rd push: rsp_err=1, sp stays 0x0020.
  - 32 pops return 32,31,...,1 and sp ends at 0x0060.
  - 33rd pop: rsp_err=1.
- Busy and mid-operation reset:
  - req_valid held during WAIT is not accepted until the cycle after RESP.
  - rst_n low during WAIT: no rsp_valid follows, sp=0x0060, state IDLE.

Source files
------------

// File: rtl/data_mem_access_unit.sv
// Data-memory initiator: turns load/store/push/pop requests into single-cycle memory strobes and owns the stack pointer.
// Latency: error -> response 1 cycle after accept; store/push -> 2 cycles; load/pop -> 3 cycles.
// Backpressure: req_ready only in IDLE (one request in flight); the response is a pulse with no backpressure.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  request handshake; req_op 00 load, 01 store, 10 push, 11 pop
//   req_addr, req_wdata  load/store byte address, store/push data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response, read data, reject flag
//   sp                   stack pointer (byte address, full-descending)
//   mem_we, mem_re, mem_addr, mem_wdata, mem_rdata  data-memory port (read data one cycle after mem_re)
module data_mem_access_unit #(
  parameter int MEM_WORDS   = 16,
  parameter int STACK_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] sp,
  output logic        mem_we,
  output logic        mem_re,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [15:0] STACK_BASE = 16'(2 * MEM_WORDS);
  localparam logic [15:0] STACK_TOP  = 16'(2 * (MEM_WORDS + STACK_WORDS));

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   req_err;
  logic   err_q;   // error flag of the request in flight, shown during RESP

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // Error checks; the stack bounds also guarantee sp arithmetic never wraps.
  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OP_LOAD, OP_STORE: req_err = req_addr[0] || (req_addr >= STACK_TOP);
      OP_PUSH:           req_err = (sp == STACK_BASE);
      default:           req_err = (sp == STACK_TOP);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                                     state_nxt = RESP;
          else if (req_op == OP_STORE || req_op == OP_PUSH) state_nxt = WRITE;
          else                                             state_nxt = READ;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = RESP;
      end
      READ: begin
        mem_re    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address/data latched at accept and held until the next
  // accepted request, so they stay stable outside WRITE/READ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp        <= STACK_TOP;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        err_q     <= req_err;
        rsp_rdata <= '0;
        if (!req_err) begin
          case (req_op)
            OP_LOAD: mem_addr <= req_addr;
            OP_STORE: begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
            end
            OP_PUSH: begin
              sp        <= sp - 16'd2;
              mem_addr  <= sp - 16'd2;
              mem_wdata <= req_wdata;
            end
            default: begin
              mem_addr <= sp;
              sp       <= sp + 16'd2;
            end
          endcase
        end
      end
      // Memory returns data the cycle after mem_re, i.e. during WAIT.
      if (state == WAIT) rsp_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Testbench for data_mem_access_unit: directed scenarios plus random traffic
// checked against a word-array/stack-pointer reference model.
module tb_data_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] sp;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  // Reference model state: word array for data+stack regions, byte stack pointer.
  logic [15:0] mem_m [0:63];
  logic [15:0] sp_m;

  // Bench-side memory device.
  logic [15:0] dev_mem [0:63];

  data_mem_access_unit #(.MEM_WORDS(16), .STACK_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sp(sp),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: cleared while reset is held, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= 16'h0;
      mem_rdata <= 16'h0;
    end else begin
      if (mem_we) dev_mem[mem_addr[6:1]] <= mem_wdata;
      if (mem_re) mem_rdata <= dev_mem[mem_addr[6:1]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = 16'h0;
    sp_m = 16'h0060;
  endtask

  // Issue one request and check every cycle up to and including its response.
  task automatic run_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd);
    logic        err, rd, exp_we, exp_re;
    logic [15:0] exp_addr, exp_rd;
    int          lat, n;
    err = 1'b0; exp_rd = 16'h0; exp_addr = addr;
    rd  = (op == 2'b00) || (op == 2'b11);
    case (op)
      2'b00, 2'b01: err = addr[0] || (addr >= 16'h0060);
      2'b10:        err = (sp_m == 16'h0020);
      default:      err = (sp_m == 16'h0060);
    endcase
    if (!err) begin
      case (op)
        2'b00: exp_rd = mem_m[addr[6:1]];
        2'b01: mem_m[addr[6:1]] = wd;
        2'b10: begin
          sp_m = sp_m - 16'd2;
          exp_addr = sp_m;
          mem_m[sp_m[6:1]] = wd;
        end
        default: begin
          exp_addr = sp_m;
          exp_rd = mem_m[sp_m[6:1]];
          sp_m = sp_m + 16'd2;
        end
      endcase
    end
    lat = err ? 1 : (rd ? 3 : 2);

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = 16'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      exp_we = !err && !rd && (k == 1);
      exp_re = !err && rd && (k == 1);
      check("mem_we", mem_we, exp_we);
      check("mem_re", mem_re, exp_re);
      check("rsp_valid", rsp_valid, (k == lat));
      check("req_ready_busy", req_ready, 0);
      if (k == 1) check("sp", sp, sp_m);
      if (exp_we || exp_re) check("mem_addr", mem_addr, exp_addr);
      if (exp_we) check("mem_wdata", mem_wdata, wd);
      if (k == lat) begin
        check("rsp_err", rsp_err, err);
        check("rsp_rdata", rsp_rdata, exp_rd);
      end
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [15:0] addr;
    int          r;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
    model_clear();

    // Reset held for two edges.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_sp", sp, 16'h0060);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_mem_wdata", mem_wdata, 16'h0);
      check("rst_rsp_rdata", rsp_rdata, 16'h0);
    end
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 1);

    // Store then load.
    run_req(2'b01, 16'h0004, 16'h00A5);
    run_req(2'b00, 16'h0004, 16'h0000);
    check("load_a5", rsp_rdata, 16'h00A5);

    // Illegal accesses.
    run_req(2'b00, 16'h0003, 16'h0000);
    run_req(2'b01, 16'h0060, 16'h1111);

    // Stack fill and drain.
    for (int i = 1; i <= 32; i++) begin
      run_req(2'b10, 16'h0000, 16'(i));
      check("sp_fill", sp, 16'(16'h0060 - 2 * i));
    end
    run_req(2'b10, 16'h0000, 16'd33);
    check("sp_full", sp, 16'h0020);
    for (int i = 32; i >= 1; i--) begin
      run_req(2'b11, 16'h0000, 16'h0000);
      check("pop_val", rsp_rdata, 16'(i));
    end
    check("sp_empty", sp, 16'h0060);
    run_req(2'b11, 16'h0000, 16'h0000);
    check("pop_empty_err", rsp_err, 1);

    // Request held while busy: load 0x0004, then a store stays pending.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h0004;
    check("busy_ready0", req_ready, 1);
    @(posedge clk);
    #1;
    req_op = 2'b01; req_addr = 16'h0008; req_wdata = 16'h1234;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("busy_not_ready", req_ready, 0);
      check("busy_no_we", mem_we, 0);
      check("busy_rsp_valid", rsp_valid, (k == 3));
      if (k == 3) check("busy_rdata", rsp_rdata, mem_m[2]);
    end
    @(negedge clk);
    check("busy_ready_after", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_m[4] = 16'h1234;
    @(negedge clk);
    check("busy_store_we", mem_we, 1);
    check("busy_store_addr", mem_addr, 16'h0008);
    check("busy_store_wdata", mem_wdata, 16'h1234);
    @(negedge clk);
    check("busy_store_rsp", rsp_valid, 1);

    // Reset during WAIT of a pop.
    run_req(2'b10, 16'h0000, 16'h0077);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11;
    check("mid_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_read", mem_re, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_sp", sp, 16'h0060);
    check("mid_rst_ready", req_ready, 0);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check("mid_after_rsp", rsp_valid, 0);
    check("mid_after_ready", req_ready, 1);
    check("mid_after_re", mem_re, 0);

    // Random traffic against the model.
    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = 16'($urandom_range(0, 127)) | 16'h0001;
      else if (r == 1) addr = 16'h0060 + 16'(2 * $urandom_range(0, 100));
      else             addr = 16'(2 * $urandom_range(0, 47));
      run_req(op, addr, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
